// File: rtl/kmp_search_pe_pkg.sv
// Shared widths and FSM encoding for the per-lane KMP search engine.
package kmp_search_pe_pkg;

    localparam int DEF_STR_AW = 6;
    localparam int DEF_PAT_AW = 4;
    localparam int DEF_CHAR_W = 8;
    localparam int DEF_NUM_PE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/kmp_search_pe_if.sv
// Controller <-> search PE job port, including the PE's string buffer read port.
interface kmp_search_pe_if
    import kmp_search_pe_pkg::*;
#(
    parameter int STR_AW = DEF_STR_AW,
    parameter int PAT_AW = DEF_PAT_AW,
    parameter int CHAR_W = DEF_CHAR_W
) ();

    logic                          pe_valid;
    logic [STR_AW-1:0]             start_idx;
    logic [STR_AW-1:0]             process_2idx;
    logic [PAT_AW-1:0]             pat_last_idx;
    logic [CHAR_W*(2**PAT_AW)-1:0] pat_flat;
    logic [STR_AW-1:0]             str_rd_addr;
    logic [CHAR_W-1:0]             str_rd_data;
    logic                          o_match_valid;
    logic                          o_match;
    logic [STR_AW-1:0]             o_match_idx;

    // Master is the controller side, which also owns the string buffer.
    modport master (
        output pe_valid, start_idx, process_2idx, pat_last_idx, pat_flat, str_rd_data,
        input  str_rd_addr, o_match_valid, o_match, o_match_idx
    );

    modport slave (
        input  pe_valid, start_idx, process_2idx, pat_last_idx, pat_flat, str_rd_data,
        output str_rd_addr, o_match_valid, o_match, o_match_idx
    );

endinterface

// File: rtl/kmp_search_pe_fail_table.sv
// KMP prefix-function builder: one step per cycle into a fail[] register array.
module kmp_fail_table #(
    parameter int PAT_AW = 4,
    parameter int CHAR_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init_i,
    input  logic                          step_i,
    input  logic [CHAR_W*(2**PAT_AW)-1:0] pat_i,
    input  logic [PAT_AW-1:0]             last_i,
    input  logic [PAT_AW-1:0]             rd_idx_i,
    output logic                          build_done_o,
    output logic [PAT_AW-1:0]             rd_fail_o
);

    localparam int PAT_N = 2**PAT_AW;

    logic [PAT_AW:0]   q_q;
    logic [PAT_AW-1:0] k_q;
    logic [PAT_AW-1:0] q_lo;
    logic [PAT_AW-1:0] fail_q [PAT_N];
    logic [CHAR_W-1:0] ch_q, ch_k;

    assign q_lo         = q_q[PAT_AW-1:0];
    assign ch_q         = pat_i[int'(q_lo)*CHAR_W +: CHAR_W];
    assign ch_k         = pat_i[int'(k_q)*CHAR_W +: CHAR_W];
    assign build_done_o = q_q > {1'b0, last_i};
    assign rd_fail_o    = fail_q[rd_idx_i];

    // fail[0] is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= (PAT_AW+1)'(1);
            k_q <= '0;
            for (int n = 0; n < PAT_N; n++) fail_q[n] <= '0;
        end else if (init_i) begin
            q_q <= (PAT_AW+1)'(1);
            k_q <= '0;
        end else if (step_i && !build_done_o) begin
            if (ch_q == ch_k) begin
                fail_q[q_lo] <= k_q + 1'b1;
                k_q          <= k_q + 1'b1;
                q_q          <= q_q + 1'b1;
            end else if (k_q != '0) begin
                k_q <= fail_q[k_q - 1'b1];
            end else begin
                fail_q[q_lo] <= '0;
                q_q          <= q_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kmp_search_pe.sv
// Per-lane KMP search engine: latch a job, build the fail table, scan the window,
// and hold the first-match verdict until the controller drops pe_valid.
module kmp_search_pe
    import kmp_search_pe_pkg::*;
#(
    parameter int STR_AW = DEF_STR_AW,
    parameter int PAT_AW = DEF_PAT_AW,
    parameter int CHAR_W = DEF_CHAR_W
) (
    input  logic            clk,
    input  logic            reset,
    kmp_search_pe_if.slave  bus
);

    state_e                        state_q;
    logic [STR_AW:0]               i_q;
    logic [STR_AW-1:0]             end_q;
    logic [PAT_AW-1:0]             last_q;
    logic [PAT_AW-1:0]             j_q;
    logic [CHAR_W*(2**PAT_AW)-1:0] pat_q;
    logic                          mv_q, m_q;
    logic [STR_AW-1:0]             idx_q;

    logic [STR_AW:0]   i_inc, idx_ext;
    logic [CHAR_W-1:0] pat_ch;
    logic [PAT_AW-1:0] fail_rd;
    logic              hit, past_end, past_end_inc, build_done;

    assign pat_ch       = pat_q[int'(j_q)*CHAR_W +: CHAR_W];
    assign hit          = pat_ch == bus.str_rd_data;
    assign i_inc        = i_q + 1'b1;
    assign past_end     = i_q > {1'b0, end_q};
    assign past_end_inc = i_inc > {1'b0, end_q};
    assign idx_ext      = i_q - (STR_AW+1)'(last_q);

    kmp_fail_table #(.PAT_AW(PAT_AW), .CHAR_W(CHAR_W)) u_fail (
        .clk          (clk),
        .reset        (reset),
        .init_i       (state_q == IDLE && bus.pe_valid),
        .step_i       (state_q == BUILD && bus.pe_valid),
        .pat_i        (pat_q),
        .last_i       (last_q),
        .rd_idx_i     (j_q - 1'b1),
        .build_done_o (build_done),
        .rd_fail_o    (fail_rd)
    );

    assign bus.str_rd_addr   = i_q[STR_AW-1:0];
    assign bus.o_match_valid = mv_q;
    assign bus.o_match       = m_q;
    assign bus.o_match_idx   = idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            end_q   <= '0;
            last_q  <= '0;
            j_q     <= '0;
            pat_q   <= '0;
            mv_q    <= 1'b0;
            m_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mv_q  <= 1'b0;
                    m_q   <= 1'b0;
                    idx_q <= '0;
                    if (bus.pe_valid) begin
                        i_q     <= {1'b0, bus.start_idx};
                        end_q   <= bus.process_2idx;
                        last_q  <= bus.pat_last_idx;
                        pat_q   <= bus.pat_flat;
                        j_q     <= '0;
                        state_q <= BUILD;
                    end
                end
                BUILD: begin
                    if (!bus.pe_valid) begin
                        i_q     <= '0;
                        state_q <= IDLE;
                    end else if (build_done) begin
                        j_q     <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!bus.pe_valid) begin
                        i_q     <= '0;
                        state_q <= IDLE;
                    end else if (past_end) begin
                        // Empty window (start > end) lands here on the first scan cycle.
                        mv_q    <= 1'b1;
                        state_q <= DONE;
                    end else if (hit && j_q == last_q) begin
                        mv_q    <= 1'b1;
                        m_q     <= 1'b1;
                        idx_q   <= idx_ext[STR_AW-1:0];
                        state_q <= DONE;
                    end else if (hit) begin
                        i_q <= i_inc;
                        j_q <= j_q + 1'b1;
                        if (past_end_inc) begin
                            mv_q    <= 1'b1;
                            state_q <= DONE;
                        end
                    end else if (j_q != '0) begin
                        j_q <= fail_rd;
                    end else begin
                        i_q <= i_inc;
                        if (past_end_inc) begin
                            mv_q    <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.pe_valid) begin
                        mv_q    <= 1'b0;
                        m_q     <= 1'b0;
                        idx_q   <= '0;
                        i_q     <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kmp_search_pe.sv
// Scoreboarded bench for kmp_search_pe: jobs push expected verdicts, verdicts pop and compare.
module tb_kmp_search_pe;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] mem [64];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       m;
        logic [5:0] idx;
        string      name;
    } exp_t;
    exp_t sb[$];

    kmp_search_pe_if #(.STR_AW(6), .PAT_AW(4), .CHAR_W(8)) bus ();

    kmp_search_pe #(.STR_AW(6), .PAT_AW(4), .CHAR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    assign bus.str_rd_data = mem[bus.str_rd_addr];

    task automatic load_str(input string s);
        for (int a = 0; a < 64; a++) mem[a] = 8'h00;
        for (int k = 0; k < s.len(); k++) mem[k] = s[k];
    endtask

    task automatic set_job(input int st, input int en, input string p);
        bus.start_idx    = 6'(st);
        bus.process_2idx = 6'(en);
        bus.pat_flat     = '0;
        for (int k = 0; k < p.len(); k++) bus.pat_flat[k*8 +: 8] = p[k];
        bus.pat_last_idx = 4'(p.len() - 1);
    endtask

    task automatic run_job(input string name, input int st, input int en, input string p,
                           input bit em, input int ei, input int maxlat);
        exp_t e;
        int   cyc;
        e.m = em; e.idx = 6'(ei); e.name = name;
        sb.push_back(e);
        set_job(st, en, p);
        bus.pe_valid = 1'b1;
        @(negedge clk);
        cyc = 1;
        // Job is latched; scrambled inputs must not affect it.
        bus.start_idx    = 6'($urandom);
        bus.process_2idx = 6'($urandom);
        bus.pat_last_idx = 4'($urandom);
        bus.pat_flat     = {4{$urandom}};
        while (!bus.o_match_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!bus.o_match_valid) begin
            errors++;
            $display("FAIL %s_timeout: no verdict after %0d cycles, required within %0d", name, cyc, maxlat);
            void'(sb.pop_front());
            bus.pe_valid = 1'b0;
            repeat (2) @(negedge clk);
            return;
        end
        if (cyc > maxlat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required <= %0d", name, cyc, maxlat);
        end
        e = sb.pop_front();
        checks++;
        if (bus.o_match !== e.m) begin
            errors++;
            $display("FAIL %s_match: got %b, required %b", e.name, bus.o_match, e.m);
        end
        checks++;
        if (bus.o_match_idx !== e.idx) begin
            errors++;
            $display("FAIL %s_idx: got %0d, required %0d", e.name, bus.o_match_idx, e.idx);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_match_valid !== 1'b1 || bus.o_match !== e.m || bus.o_match_idx !== e.idx) begin
            errors++;
            $display("FAIL %s_hold: got v=%b m=%b idx=%0d, required v=1 m=%b idx=%0d",
                     e.name, bus.o_match_valid, bus.o_match, bus.o_match_idx, e.m, e.idx);
        end
        bus.pe_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_match_valid !== 1'b0 || bus.o_match !== 1'b0 || bus.o_match_idx !== 6'd0) begin
            errors++;
            $display("FAIL %s_clear: got v=%b m=%b idx=%0d, required all 0",
                     e.name, bus.o_match_valid, bus.o_match, bus.o_match_idx);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.pe_valid = 1'b0;
        set_job(0, 0, "A");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_match_valid !== 1'b0 || bus.o_match !== 1'b0 || bus.o_match_idx !== 6'd0 ||
            bus.str_rd_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b m=%b idx=%0d addr=%0d, required all 0",
                     bus.o_match_valid, bus.o_match, bus.o_match_idx, bus.str_rd_addr);
        end
    endtask

    task automatic test_basic;
        logic [3:0] exp_fail [4];
        exp_fail[0] = 4'd0; exp_fail[1] = 4'd0; exp_fail[2] = 4'd1; exp_fail[3] = 4'd2;
        load_str("ABABCABAB");
        run_job("abab", 0, 8, "ABAB", 1'b1, 0, 26);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut.u_fail.fail_q[k] !== exp_fail[k]) begin
                errors++;
                $display("FAIL abab_fail%0d: got %0d, required %0d", k, dut.u_fail.fail_q[k], exp_fail[k]);
            end
        end
        run_job("cab_abs", 2, 8, "CAB", 1'b1, 4, 20);
    endtask

    task automatic test_backtrack;
        load_str("AAAAAB");
        run_job("aab", 0, 5, "AAB", 1'b1, 3, 18);
    endtask

    task automatic test_nomatch;
        load_str("ABCDEF");
        run_job("xy_none", 3, 5, "XY", 1'b0, 0, 10);
    endtask

    task automatic test_single_char;
        load_str("");
        mem[7] = "A";
        run_job("single", 7, 7, "A", 1'b1, 7, 4);
        run_job("empty_win", 8, 7, "A", 1'b0, 0, 4);
    endtask

    task automatic test_abort;
        bit stale;
        load_str("AAAAAAAAAAAAABAB");
        set_job(0, 15, "ABAB");
        bus.pe_valid = 1'b1;
        repeat (7) @(negedge clk);
        bus.pe_valid = 1'b0;
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_match_valid !== 1'b0 || bus.o_match !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL abort_stale: verdict seen after abort, required none");
        end
        run_job("after_abort", 10, 15, "ABAB", 1'b1, 12, 30);
    endtask

    task automatic test_reset_mid_build;
        load_str("ABABCABAB");
        set_job(0, 8, "ABAB");
        bus.pe_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.pe_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_match_valid !== 1'b0 || bus.o_match !== 1'b0 || bus.o_match_idx !== 6'd0 ||
            bus.str_rd_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid_build: got v=%b m=%b idx=%0d addr=%0d, required all 0",
                     bus.o_match_valid, bus.o_match, bus.o_match_idx, bus.str_rd_addr);
        end
        run_job("post_reset", 4, 8, "BAB", 1'b1, 6, 20);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backtrack();
        test_nomatch();
        test_single_char();
        test_abort();
        test_reset_mid_build();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
